// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC3 instruction-fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3_fetch_pkg;

    // IDLE: nothing outstanding; REQ: request outstanding and its word is kept;
    // SQUASH: request outstanding but its word is thrown away (redirect pending).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] npc;
    } fetch_entry_t;

    localparam logic [15:0] LC3_RESET_PC = 16'h3000;

endpackage

// File: rtl/lc3_fetch_buf.sv
// Fetch buffer: small FIFO of {instr, npc} entries between fetch and decode.
// Latency: a pushed entry is visible at head_o the cycle after the push.
// Backpressure: caller must not push when full (credit-checked upstream); flush wins over push/pop.
//
// Ports: clk_i/rst_i (async active-high), push_i/entry_i write, pop_i read,
//        flush_i empties the buffer, head_o oldest entry, count_o occupancy.
module lc3_fetch_buf
    import lc3_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  fetch_entry_t             entry_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t         mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 do_push;
    logic                 do_pop;

    // Guards keep the pointers consistent even if a caller misbehaves.
    assign do_push = push_i & ~flush_i & (count_q != CW'(DEPTH));
    assign do_pop  = pop_i  & ~flush_i & (count_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is only consumed when count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/lc3_fetch.sv
// LC3 fetch stage: issues PC/instrmem_rd, captures instr_dout, buffers words toward decode.
// Latency: request one cycle after issue; word at fd_* one cycle after memory completion.
// Backpressure: new requests issue only while a buffer slot will be free; fd_valid/fd_ready handshake to decode.
//
// Ports: clock/reset (async active-high); enable_fetch gates issue; br_taken/taddr redirect;
//        PC/instrmem_rd/instr_dout/complete_instr memory side; fd_valid/fd_ready/fd_instr/fd_npc decode side.
module lc3_fetch
    import lc3_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = LC3_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_fetch,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    output logic [15:0] PC,
    output logic        instrmem_rd,
    input  logic [15:0] instr_dout,
    input  logic        complete_instr,
    output logic        fd_valid,
    input  logic        fd_ready,
    output logic [15:0] fd_instr,
    output logic [15:0] fd_npc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   pend_q, pend_d;
    logic          rd_q, rd_d;

    logic [CW-1:0] count;
    logic [CW-1:0] occ_after;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          complete;
    logic          push;
    logic          pop;
    logic          issue_ok;

    assign complete = rd_q & complete_instr;
    assign fd_valid = (count != '0);
    assign pop      = fd_valid & fd_ready;
    // Only a kept completion with no redirect in the same cycle lands in the buffer.
    assign push     = (state_q == REQ) & complete & ~br_taken;

    // Occupancy after this edge; a new request needs a slot that will still be free
    // when its word returns, so count the push and pop happening right now.
    assign occ_after = count + CW'(push) - CW'(pop);
    assign issue_ok  = enable_fetch & ~br_taken & (occ_after < CW'(BUF_DEPTH));

    assign push_entry = '{instr: instr_dout, npc: pc_q + 16'd1};

    lc3_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (br_taken),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (br_taken) begin
                    pc_d = taddr;
                end else if (issue_ok) begin
                    state_d = REQ;
                    rd_d    = 1'b1;
                end
            end
            REQ: begin
                if (complete) begin
                    if (br_taken) begin
                        pc_d    = taddr;
                        state_d = IDLE;
                        rd_d    = 1'b0;
                    end else begin
                        pc_d = pc_q + 16'd1;
                        if (issue_ok) begin
                            state_d = REQ;
                            rd_d    = 1'b1;
                        end else begin
                            state_d = IDLE;
                            rd_d    = 1'b0;
                        end
                    end
                end else if (br_taken) begin
                    // Memory forbids changing PC mid-request: remember the target, hold the request.
                    pend_d  = taddr;
                    state_d = SQUASH;
                end
            end
            SQUASH: begin
                if (complete) begin
                    // A redirect on the completing edge is the newest target.
                    pc_d    = br_taken ? taddr : pend_q;
                    state_d = IDLE;
                    rd_d    = 1'b0;
                end else if (br_taken) begin
                    pend_d = taddr;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            rd_q    <= rd_d;
        end
    end

    assign PC          = pc_q;
    assign instrmem_rd = rd_q;
    assign fd_instr    = fd_valid ? head.instr : 16'h0000;
    assign fd_npc      = fd_valid ? head.npc   : 16'h0000;

endmodule

// File: tb/tb_lc3_fetch.sv
// Testbench for lc3_fetch: directed scenarios followed by a randomized run against a stream model.
// Latency: n/a.
// Backpressure: fd_ready and memory wait states are driven by the bench.
module tb_lc3_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_fetch = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] taddr = 16'h0000;
    logic [15:0] PC;
    logic        instrmem_rd;
    logic [15:0] instr_dout = 16'h0000;
    logic        complete_instr = 1'b0;
    logic        fd_valid;
    logic        fd_ready = 1'b0;
    logic [15:0] fd_instr;
    logic [15:0] fd_npc;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lc3_fetch #(
        .RESET_PC  (16'h3000),
        .BUF_DEPTH (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable_fetch   (enable_fetch),
        .br_taken       (br_taken),
        .taddr          (taddr),
        .PC             (PC),
        .instrmem_rd    (instrmem_rd),
        .instr_dout     (instr_dout),
        .complete_instr (complete_instr),
        .fd_valid       (fd_valid),
        .fd_ready       (fd_ready),
        .fd_instr       (fd_instr),
        .fd_npc         (fd_npc)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
        instr_dout = memf(PC);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        enable_fetch   = 1'b0;
        br_taken       = 1'b0;
        complete_instr = 1'b0;
        fd_ready       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic        hs, was_br, pend, done;
    logic [15:0] t, ppc, obs_npc, obs_instr, exp_addr;
    int          wcnt, delivered, guard;

    initial begin
        // ---- T1: reset state, then zero-wait streaming
        do_reset();
        chkb("rst_rd", instrmem_rd, 1'b0);
        chk ("rst_pc", PC, 16'h3000);
        chkb("rst_fdv", fd_valid, 1'b0);
        chk ("rst_fdi", fd_instr, 16'h0000);
        chk ("rst_fdn", fd_npc, 16'h0000);
        enable_fetch = 1'b1; fd_ready = 1'b1; complete_instr = 1'b1;
        tick();
        chkb("t1_rd", instrmem_rd, 1'b1);
        chk ("t1_pc0", PC, 16'h3000);
        tick();
        chk ("t1_pc1", PC, 16'h3001);
        chkb("t1_fdv", fd_valid, 1'b1);
        chk ("t1_npc1", fd_npc, 16'h3001);
        chk ("t1_ins1", fd_instr, memf(16'h3000));
        tick();
        chk ("t1_pc2", PC, 16'h3002);
        chk ("t1_npc2", fd_npc, 16'h3002);
        tick();
        chk ("t1_npc3", fd_npc, 16'h3003);

        // ---- T2: three wait states
        do_reset();
        enable_fetch = 1'b1; fd_ready = 1'b1; complete_instr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk ("t2_pc_hold", PC, 16'h3000);
            chkb("t2_rd_hold", instrmem_rd, 1'b1);
        end
        chkb("t2_fdv_wait", fd_valid, 1'b0);
        complete_instr = 1'b1;
        tick();
        complete_instr = 1'b0;
        chk ("t2_pc_after", PC, 16'h3001);
        chkb("t2_fdv", fd_valid, 1'b1);
        chk ("t2_npc", fd_npc, 16'h3001);
        chk ("t2_ins", fd_instr, memf(16'h3000));
        tick();
        chkb("t2_one_push", fd_valid, 1'b0);
        chk ("t2_pc_next", PC, 16'h3001);

        // ---- T3: decode stalled, buffer fills and fetch stops
        do_reset();
        enable_fetch = 1'b1; fd_ready = 1'b0; complete_instr = 1'b1;
        tick(); tick(); tick();
        chkb("t3_rd_off", instrmem_rd, 1'b0);
        chk ("t3_pc", PC, 16'h3002);
        chkb("t3_fdv", fd_valid, 1'b1);
        chk ("t3_npc", fd_npc, 16'h3001);
        chk ("t3_ins", fd_instr, memf(16'h3000));
        tick();
        chkb("t3_rd_held", instrmem_rd, 1'b0);
        chk ("t3_pc_held", PC, 16'h3002);
        fd_ready = 1'b1;
        for (int i = 0; i < 4 && !instrmem_rd; i++) tick();
        chkb("t3_rd_again", instrmem_rd, 1'b1);
        chk ("t3_pc_again", PC, 16'h3002);

        // ---- T4: redirect during a wait state
        do_reset();
        enable_fetch = 1'b1; fd_ready = 1'b1; complete_instr = 1'b1;
        for (int i = 0; i < 20 && !(instrmem_rd && PC == 16'h3005); i++) tick();
        chk ("t4_reach", PC, 16'h3005);
        complete_instr = 1'b0;
        tick();
        br_taken = 1'b1; taddr = 16'h4000;
        tick();
        br_taken = 1'b0;
        chkb("t4_flush", fd_valid, 1'b0);
        chk ("t4_pc_hold", PC, 16'h3005);
        chkb("t4_rd_hold", instrmem_rd, 1'b1);
        complete_instr = 1'b1;
        tick();
        chk ("t4_pc_tgt", PC, 16'h4000);
        chkb("t4_rd_idle", instrmem_rd, 1'b0);
        chkb("t4_drop", fd_valid, 1'b0);
        tick();
        chkb("t4_rd_tgt", instrmem_rd, 1'b1);
        chk ("t4_pc_req", PC, 16'h4000);
        tick();
        chkb("t4_fdv", fd_valid, 1'b1);
        chk ("t4_npc", fd_npc, 16'h4001);
        chk ("t4_ins", fd_instr, memf(16'h4000));

        // ---- T5: second redirect during SQUASH wins
        complete_instr = 1'b0;
        tick();
        ppc = PC;
        br_taken = 1'b1; taddr = 16'h4000;
        tick();
        taddr = 16'h5000;
        tick();
        br_taken = 1'b0;
        chkb("t5_rd_hold", instrmem_rd, 1'b1);
        chk ("t5_pc_hold", PC, ppc);
        complete_instr = 1'b1;
        tick();
        chk ("t5_pc_tgt", PC, 16'h5000);
        tick();
        chkb("t5_rd", instrmem_rd, 1'b1);
        chk ("t5_pc_req", PC, 16'h5000);
        tick();
        chk ("t5_npc", fd_npc, 16'h5001);

        // ---- T6: PC wrap, then async reset mid-request
        complete_instr = 1'b0;
        tick();
        br_taken = 1'b1; taddr = 16'hFFFF;
        tick();
        br_taken = 1'b0; complete_instr = 1'b1;
        tick();
        chk ("t6_pc_ffff", PC, 16'hFFFF);
        tick();
        chkb("t6_rd", instrmem_rd, 1'b1);
        chk ("t6_pc_req", PC, 16'hFFFF);
        tick();
        chk ("t6_pc_wrap", PC, 16'h0000);
        chk ("t6_npc_wrap", fd_npc, 16'h0000);
        chk ("t6_ins", fd_instr, memf(16'hFFFF));
        complete_instr = 1'b0;
        tick();
        chkb("t6_rd_pre", instrmem_rd, 1'b1);
        #2 reset = 1'b1;
        #1;
        chkb("t6_arst_rd", instrmem_rd, 1'b0);
        chk ("t6_arst_pc", PC, 16'h3000);
        chkb("t6_arst_fdv", fd_valid, 1'b0);

        // ---- Randomized run: delivered stream must be contiguous from the last redirect
        do_reset();
        exp_addr  = 16'h3000;
        delivered = 0;
        wcnt      = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            enable_fetch = ($urandom_range(0, 7) != 0);
            fd_ready     = ($urandom_range(0, 3) != 0);
            br_taken     = ($urandom_range(0, 39) == 0);
            taddr        = 16'($urandom);
            if (instrmem_rd) complete_instr = (wcnt == 0);
            else             complete_instr = 1'($urandom_range(0, 1));
            hs        = fd_valid & fd_ready;
            obs_npc   = fd_npc;
            obs_instr = fd_instr;
            was_br    = br_taken;
            t         = taddr;
            pend      = instrmem_rd & ~complete_instr;
            done      = instrmem_rd & complete_instr;
            ppc       = PC;
            tick();
            if (was_br) begin
                exp_addr = t;
            end else if (hs) begin
                chk("rnd_npc", obs_npc, exp_addr + 16'd1);
                chk("rnd_ins", obs_instr, memf(exp_addr));
                exp_addr = exp_addr + 16'd1;
                delivered++;
            end
            if (pend) begin
                chkb("rnd_rd_stable", instrmem_rd, 1'b1);
                chk ("rnd_pc_stable", PC, ppc);
            end
            if (done) wcnt = $urandom_range(0, 3);
            else if (pend && wcnt != 0) wcnt--;
        end
        guard = (delivered > 200) ? 1 : 0;
        chkb("rnd_progress", guard[0], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_fetch.md
Name: lc3_fetch

Overview:
- Instruction-fetch stage of the LC3 core; sits directly upstream of instruction memory.
- Drives PC/instrmem_rd, waits for the memory's complete_instr handshake and captures instr_dout.
- Buffers fetched words in a small FIFO toward decode, with valid/ready flow control.
- Handles branch redirects, including squashing an in-flight fetch.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.
- BUF_DEPTH, 2, fetch-buffer entries (power of 2, ≥2).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable_fetch  in  1  permits issuing new fetch requests
- br_taken  in  1  redirect strobe, single-cycle
- taddr  in  16  redirect target, valid with br_taken
- PC  out  16  fetch address to instruction memory
- instrmem_rd  out  1  fetch request to instruction memory
- instr_dout  in  16  instruction word from memory
- complete_instr  in  1  memory completion for the current request
- fd_valid  out  1  buffer head valid toward decode
- fd_ready  in  1  decode accepts head
- fd_instr  out  16  head instruction
- fd_npc  out  16  head fetch address + 1

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_PC, instrmem_rd=0, state=IDLE, buffer empty.
  - fd_valid=0, fd_instr=0, fd_npc=0.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, result kept.
  - SQUASH: request outstanding, result discarded.
- Credit: `slots_free = BUF_DEPTH - count`.
  - A request may issue only if enable_fetch=1, slots_free≥1 and no br_taken this cycle.
- IDLE→REQ: on issue.
  - Next cycle instrmem_rd=1 and PC holds the fetch address.
  - PC and instrmem_rd stay stable until completion.
- Completion is a clock edge with instrmem_rd=1 and complete_instr=1. Zero extra wait states are legal (complete_instr high in the first request cycle).
- REQ completion:
  - Push {instr_dout, PC+1}; PC<=PC+1 (16-bit wrap, FFFF→0000).
  - If issue is still permitted, stay in REQ with instrmem_rd=1 (back-to-back fetch at the new PC, one word per cycle max). Otherwise go to IDLE with instrmem_rd=0.
- br_taken in IDLE:
  - PC<=taddr, buffer flushed; next cycle may issue at taddr.
- br_taken in REQ without completion the same cycle:
  - Latch taddr in a pending_target register, flush buffer, go to SQUASH.
  - instrmem_rd and PC are held unchanged (the memory protocol forbids a mid-request change).
- br_taken in REQ on the completion edge:
  - Discard the returned word, flush buffer, PC<=taddr.
  - Go to IDLE; the next request issues the following cycle if permitted.
- SQUASH completion:
  - Drop data, PC<=pending_target, instrmem_rd=0, go to IDLE.
  - A br_taken arriving during SQUASH overwrites pending_target (last target wins).
- Buffer: FIFO, head drives fd_instr/fd_npc.
  - Pop when fd_valid & fd_ready.
  - Push and pop in the same cycle keep count unchanged.
  - A flush overrides both push and pop in that cycle.
  - Credit rule guarantees push never occurs when full.
  - Pop on empty is impossible since fd_valid=0.
- enable_fetch deasserted while in REQ: the outstanding request completes normally, no new issue.
- Reset mid-request: instrmem_rd drops immediately (async); pending data lost.

Decomposition:
- lc3_fetch_pkg holds:
  - fetch_state_e {IDLE, REQ, SQUASH}
  - fetch_entry_t {instr[15:0], npc[15:0]}
  - LC3_RESET_PC
- One sub-module, lc3_fetch_buf: parameterized FIFO of fetch_entry_t with push, pop, flush, count.

Test Plan:
- Reset, enable_fetch=1, fd_ready=1, complete_instr tied high → instrmem_rd=1, PC=3000,3001,3002 on consecutive cycles; fd_npc=3001,3002,3003.
- Memory with 3 wait states → PC stable at 3000 for 4 cycles; exactly one push; PC=3001 after completion.
- fd_ready=0, zero-wait memory → two words buffered (3000, 3001), instrmem_rd=0, PC=3002 held. Raise fd_ready → instrmem_rd reasserts at 3002.
- br_taken with taddr=4000 during wait state at PC=3005 → word for 3005 discarded, buffer flushed, fd_valid=0. Next request at PC=4000; first fd_npc=4001.
- Second br_taken (taddr=5000) during SQUASH after first to 4000 → next fetch at 5000; no 4000 fetch.
- PC=FFFF, zero-wait → fd_npc=0000, next PC=0000. Async reset asserted mid-request → instrmem_rd=0 and PC=3000 without a clock edge.
